// File: rtl/fifo_read_stream_adapter.sv
// Turns a first-word-fall-through-less FIFO read port (data one cycle after rd_en)
// into a valid/ready stream through a 3-entry skid buffer with registered flow control.
`timescale 1ns/1ps

module fifo_read_stream_adapter #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 10
) (
    input  logic                   clock,
    input  logic                   resetn,
    output logic                   rd_en,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    input  logic                   empty,
    input  logic                   almost_empty,
    input  logic [COUNT_WIDTH-1:0] rd_data_count,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic [COUNT_WIDTH+1:0] level,
    output logic                   low_water
);

    localparam int LEVEL_WIDTH = COUNT_WIDTH + 2;

    logic [DATA_WIDTH-1:0] buffer [3];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [1:0]            occ;
    logic [1:0]            occ_next;
    logic                  inflight;
    logic                  capture;
    logic                  pop;
    logic [2:0]            committed;

    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    endfunction

    // Slots already promised (stored + in flight) decide whether another read fits;
    // m_ready is deliberately absent so the read request has no path from the consumer.
    assign committed = {1'b0, occ} + {2'b0, inflight};
    assign rd_en     = resetn && !empty && (committed < 3'd3);

    assign m_valid = resetn && (occ != 2'd0);
    assign m_data  = buffer[rd_ptr];
    assign capture = inflight;
    assign pop     = m_valid && m_ready;

    // NOTE: every path assigns occ_next via the default first, so no latch is inferred.
    always_comb begin
        occ_next = occ;
        case ({capture, pop})
            2'b10:   occ_next = occ + 2'd1;
            2'b01:   occ_next = occ - 2'd1;
            default: occ_next = occ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            occ       <= 2'd0;
            inflight  <= 1'b0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            level     <= '0;
            low_water <= 1'b0;
        end else begin
            occ       <= occ_next;
            inflight  <= rd_en;
            if (capture) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            level     <= LEVEL_WIDTH'(rd_data_count) + LEVEL_WIDTH'(inflight)
                       + LEVEL_WIDTH'(occ);
            low_water <= almost_empty && (occ <= 2'd1);
        end
    end

    // NOTE: buffer storage has no reset; occ gates visibility, so stale contents never escape.
    always_ff @(posedge clock) begin
        if (capture) buffer[wr_ptr] <= rd_data;
    end

    assert property (@(posedge clock) disable iff (!resetn) capture |-> (occ != 2'd3))
        else $error("capture into a full output buffer");

endmodule

// File: tb/tb_fifo_read_stream_adapter.sv
// Bench for fifo_read_stream_adapter: behavioural FIFO model feeding the DUT and a
// scoreboard queue of words expected on the stream side, plus level/low_water model.
`timescale 1ns/1ps

module tb_fifo_read_stream_adapter;

    localparam int DW = 32;
    localparam int CW = 10;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          rd_en;
    logic [DW-1:0] rd_data = '0;
    logic          empty = 1'b1;
    logic          almost_empty = 1'b1;
    logic [CW-1:0] rd_data_count = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [CW+1:0] level;
    logic          low_water;

    always #5 clock = ~clock;

    fifo_read_stream_adapter #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .empty         (empty),
        .almost_empty  (almost_empty),
        .rd_data_count (rd_data_count),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .level         (level),
        .low_water     (low_water)
    );

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q  [$];
    int            held = 0;
    bit            prev_rd_en = 1'b0;
    bit            hold_empty = 1'b0;
    int            pops = 0;
    bit            s_reset, s_rd_en, s_valid, s_pop;
    logic [DW-1:0] s_data;
    int            exp_level;
    bit            exp_low;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic update_inputs();
        empty         = (fifo_q.size() == 0) || hold_empty;
        rd_data_count = CW'(fifo_q.size());
        almost_empty  = (fifo_q.size() <= 4);
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        update_inputs();
    endtask

    // One clock cycle: sample at negedge, then apply FIFO/scoreboard effects after posedge.
    task automatic tick();
        @(negedge clock);
        s_reset = !resetn;
        s_rd_en = rd_en;
        s_valid = m_valid;
        s_pop   = m_valid && m_ready;
        s_data  = m_data;
        check("rd_en_while_empty", rd_en && empty, 0);
        if (s_reset) begin
            check("rst_rd_en", s_rd_en, 0);
            check("rst_m_valid", s_valid, 0);
        end
        exp_level = fifo_q.size() + held;
        exp_low   = almost_empty && ((held - int'(prev_rd_en)) <= 1);
        @(posedge clock);
        #1;
        if (s_reset) begin
            held       = 0;
            prev_rd_en = 1'b0;
            check("rst_level", level, 0);
            check("rst_low_water", low_water, 0);
        end else begin
            if (s_rd_en) rd_data = (fifo_q.size() > 0) ? fifo_q.pop_front() : 'x;
            if (s_pop) begin
                pops++;
                check("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("beat_data", s_data, exp_q.pop_front());
            end
            held = held + int'(s_rd_en) - int'(s_pop);
            check("held_max", held <= 3, 1);
            check("level", level, exp_level);
            check("low_water", low_water, exp_low);
            prev_rd_en = s_rd_en;
        end
        update_inputs();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || held != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", exp_q.size() + held, 0);
    endtask

    initial begin
        int rd_cnt;
        int pushed;
        int start_pops;
        int cycles;

        // Reset with a non-empty FIFO: no reads, no beats, level held at zero.
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'hEEEE_0000 + DW'(i));
        update_inputs();
        repeat (2) tick();
        fifo_q.delete();
        exp_q.delete();
        update_inputs();
        resetn = 1'b1;

        // First-word latency.
        m_ready = 1'b1;
        push_word(32'hA5A5_0001);
        tick();
        check("lat_rd_en_c0", s_rd_en, 1);
        check("lat_valid_c0", s_valid, 0);
        tick();
        check("lat_valid_c1", s_valid, 0);
        tick();
        check("lat_valid_c2", s_valid, 1);
        check("lat_data_c2", s_data, 32'hA5A5_0001);
        check("lat_pop_c2", s_pop, 1);
        tick();
        check("lat_valid_c3", s_valid, 0);

        // Back-pressure: only three reads issued, head word held steady.
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(32'hB000_0000 + DW'(i));
        rd_cnt = 0;
        repeat (8) begin
            tick();
            rd_cnt += int'(s_rd_en);
            if (s_valid) check("bp_head_stable", s_data, 32'hB000_0000);
        end
        check("bp_rd_en_pulses", rd_cnt, 3);
        check("bp_held", held, 3);
        m_ready    = 1'b1;
        start_pops = pops;
        drain(50);
        check("bp_beats", pops - start_pops, 8);

        // Streaming at full rate across many pointer wraps.
        for (int i = 0; i < 100; i++) push_word(DW'(i));
        tick();
        tick();
        for (int i = 0; i < 100; i++) begin
            tick();
            check("stream_beat", s_pop, 1);
        end
        tick();
        check("stream_idle", s_valid, 0);

        // Random FIFO availability and consumer stalls.
        pushed     = 0;
        cycles     = 0;
        start_pops = pops;
        while ((pops - start_pops) < 1000 && cycles < 20000) begin
            if (pushed < 1000) begin
                int k = $urandom_range(0, 2);
                for (int j = 0; j < k && pushed < 1000; j++) begin
                    push_word(32'h5000_0000 + DW'(pushed));
                    pushed++;
                end
            end
            hold_empty = ($urandom_range(0, 3) == 0);
            m_ready    = ($urandom_range(0, 2) != 0);
            update_inputs();
            tick();
            cycles++;
        end
        hold_empty = 1'b0;
        m_ready    = 1'b1;
        update_inputs();
        check("rand_all_words", pops - start_pops, 1000);
        drain(20);

        // Reset mid-stream with two words buffered and one in flight.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'hC000_0000 + DW'(i));
        repeat (3) tick();
        check("mid_held", held, 3);
        check("mid_inflight", prev_rd_en, 1);
        resetn = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        update_inputs();
        tick();
        resetn = 1'b1;
        #1;
        check("mid_valid_after_rst", m_valid, 0);
        m_ready = 1'b1;
        push_word(32'hD000_0001);
        push_word(32'hD000_0002);
        cycles = 0;
        s_valid = 1'b0;
        while (!s_valid && cycles < 10) begin
            tick();
            cycles++;
        end
        check("mid_first_beat_seen", s_valid, 1);
        check("mid_first_beat", s_data, 32'hD000_0001);
        drain(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
